sdram_image_writer: RTL and testbench
=====================================

Name: sdram_image_writer

Overview:
- Downstream of the JTAG-UART image decoder, on the read side of its pixel FIFO.
- When triggered, drains exactly iNUM_IMAGES frames of 8-bit pixels from the FIFO.
- Packs pixel pairs into 16-bit words and writes them to consecutive SDRAM word addresses through a simple wait-request write master.
- Runs in the SDRAM-side clock domain; the FIFO read clock is iCLK.

Parameters:
- FRAME_BYTES_LOG2, 20, log2 of bytes per frame; 1024x1024 8-bit pixels.
- ADDR_W, 25, SDRAM word-address width; must be >= FRAME_BYTES_LOG2-1+6.
- BASE_ADDR, 0, word address of pixel 0 of frame 0.

Ports:
- iCLK  in  1  SDRAM-domain clock; also FIFO read clock
- iRST  in  1  reset
- iTRIGGER  in  1  one-cycle start pulse, already synchronous to iCLK
- iNUM_IMAGES  in  7  frame count, 1..64, sampled on accepted trigger
- oFIFO_RDREQ  out  1  FIFO read request; normal mode, data valid the cycle after
- iFIFO_DATA  in  8  FIFO q
- iFIFO_EMPTY  in  1  FIFO rdempty
- oWR_REQ  out  1  SDRAM write request
- oWR_ADDR  out  ADDR_W  SDRAM word address
- oWR_DATA  out  16  SDRAM write data
- iWR_WAIT  in  1  waitrequest; a write completes on a cycle with oWR_REQ=1 and iWR_WAIT=0
- oBUSY  out  1  high from accepted trigger until the last write completes
- oDONE  out  1  one-cycle pulse after the last write completes
- oFRAMES_DONE  out  7  count of fully written frames in the current run
- oERROR  out  1  sticky error flag

Behaviour:
- Reset and polarity: reset iRST, asynchronous, active-high; clock iCLK.
- Reset values: all outputs 0; state IDLE; oWR_ADDR = BASE_ADDR.
- Derived constants: WPF = 2^(FRAME_BYTES_LOG2-1) words per frame; total_words = num_images*WPF, 26-bit unsigned.
- States:
  - IDLE: on iTRIGGER:
    - If iNUM_IMAGES in 1..64: latch it, set word_idx=0, oFRAMES_DONE=0, oERROR=0, oBUSY=1, go to RD_LO.
    - Otherwise (0 or >64): set oERROR=1 and stay in IDLE.
  - RD_LO: oFIFO_RDREQ = !iFIFO_EMPTY, combinational. If asserted, go to CAP_LO; otherwise stay, with no timeout.
  - CAP_LO: oWR_DATA[7:0] <= iFIFO_DATA; go to RD_HI.
  - RD_HI: same as RD_LO, going to CAP_HI.
  - CAP_HI: oWR_DATA[15:8] <= iFIFO_DATA; go to WRITE.
  - WRITE:
    - oWR_REQ=1, oWR_ADDR = BASE_ADDR + word_idx; addr and data held stable while iWR_WAIT=1.
    - On completion, if word_idx[FRAME_BYTES_LOG2-2:0] is all ones, increment oFRAMES_DONE.
    - If word_idx == total_words-1: oBUSY=0, oDONE=1 for the next cycle, go to IDLE.
    - Otherwise word_idx++ and go to RD_LO.
- Byte order: the first FIFO byte is the low byte. Every FIFO byte, 0xFE included, is pixel data.
- oFIFO_RDREQ is never asserted outside RD_LO/RD_HI, and never while empty. No FIFO over-read past total_words*2 bytes.
- Minimum throughput: 5 cycles per word with FIFO non-empty and iWR_WAIT=0.
- iTRIGGER while oBUSY=1: ignored (run continues unchanged); oERROR set.
- oERROR clears only on reset or on the next accepted trigger.
- iTRIGGER in the same cycle as the final write completion: ignored, since the state is still WRITE; oERROR set.
- 64 frames: total_words = 2^25 at default; last oWR_ADDR = BASE_ADDR + 2^25-1, which must not overflow ADDR_W.
- Reset mid-run: immediate return to IDLE with all outputs 0. No oDONE. FIFO contents are not touched (the upstream block clears the FIFO).

Decomposition:
- Shared package: FRAME_BYTES_LOG2, MAX_IMAGES=64, and the state encodings IDLE/RD_LO/CAP_LO/RD_HI/CAP_HI/WRITE. The decoder uses the same frame-size constant.
- No sub-module required. The byte-pair packer is inline (two capture registers).

Test Plan (FRAME_BYTES_LOG2=4, so WPF=8, unless stated):
- Single frame, no wait:
  - Stimulus: preload FIFO with bytes 0x00..0x0F; iNUM_IMAGES=1; pulse iTRIGGER.
  - Response: 8 writes, addr 0..7, data 0x0100, 0x0302 ... 0x0F0E; oFRAMES_DONE=1; one oDONE pulse; oBUSY low afterwards; 16 rdreqs.
- Starved FIFO:
  - Stimulus: iNUM_IMAGES=2; feed one byte every 10 cycles.
  - Response: rdreq only while non-empty; 16 writes, addr 0..15; oFRAMES_DONE steps 1 then 2; data 0xFE passes unchanged.
- Wait-request:
  - Stimulus: iWR_WAIT high for 3 cycles on every write.
  - Response: oWR_ADDR and oWR_DATA are stable throughout each wait; each address is written exactly once.
- Illegal triggers:
  - Stimulus: iNUM_IMAGES=0 trigger; then iNUM_IMAGES=65 trigger.
  - Response: oERROR=1, oBUSY stays 0, no writes.
  - Then a valid trigger with iNUM_IMAGES=1: oERROR cleared.
- Trigger during a run:
  - Stimulus: a second iTRIGGER with iNUM_IMAGES=3 during a 1-frame run.
  - Response: still exactly 8 writes; oERROR=1 at the end.
- Reset and max count:
  - Stimulus: assert iRST after 3 writes, then re-trigger with iNUM_IMAGES=64.
  - Response: outputs 0 immediately, no oDONE; on re-trigger, last addr = 511 and oFRAMES_DONE=64.

Source files
------------

// File: rtl/sdram_image_writer_pkg.sv
// -----------------------------------------------------------------------------
// sdram_image_writer_pkg
// Shared definitions for the image writer and its neighbours in the capture
// path. The frame-size constant is the same one used by the JTAG-UART image
// decoder, so both blocks agree on how many bytes make up one frame.
// Contents: frame size, maximum frame count, writer state encoding, and a
// helper that validates a requested frame count.
// -----------------------------------------------------------------------------
package sdram_image_writer_pkg;

  // log2 of bytes per frame: 1024 x 1024 pixels of 8 bits each.
  localparam int FRAME_BYTES_LOG2 = 20;

  // Largest number of frames a single run may request.
  localparam int MAX_IMAGES = 64;

  // Width of the frame-count fields.
  localparam int NUM_W = 7;

  // Writer states: fetch low byte, capture it, fetch high byte, capture it,
  // then issue the 16-bit write.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    CAP_LO = 3'd2,
    RD_HI  = 3'd3,
    CAP_HI = 3'd4,
    WRITE  = 3'd5
  } state_e;

  // A run may request between 1 and MAX_IMAGES frames inclusive.
  function automatic logic num_images_ok(input logic [NUM_W-1:0] num);
    return (num != 7'd0) && (num <= 7'(MAX_IMAGES));
  endfunction

endpackage

// File: rtl/sdram_image_writer_if.sv
// -----------------------------------------------------------------------------
// sdram_image_writer_if
// Bundles the two data-path buses of the image writer:
//   FIFO read side : fifo_rdreq (writer out), fifo_data / fifo_empty (writer in)
//                    Normal-mode FIFO: fifo_data is valid the cycle after
//                    fifo_rdreq.
//   SDRAM write    : wr_req / wr_addr / wr_data (writer out), wr_wait (writer in)
//                    A write completes on a cycle with wr_req=1 and wr_wait=0.
// Modports: master = the image writer, slave = FIFO + SDRAM controller side.
// -----------------------------------------------------------------------------
interface sdram_image_writer_if #(
  parameter int ADDR_W = 25
);

  logic              fifo_rdreq;
  logic [7:0]        fifo_data;
  logic              fifo_empty;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              wr_wait;

  modport master (
    output fifo_rdreq,
    input  fifo_data,
    input  fifo_empty,
    output wr_req,
    output wr_addr,
    output wr_data,
    input  wr_wait
  );

  modport slave (
    input  fifo_rdreq,
    output fifo_data,
    output fifo_empty,
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    output wr_wait
  );

endinterface

// File: rtl/sdram_image_writer.sv
// -----------------------------------------------------------------------------
// sdram_image_writer
// On a trigger, drains iNUM_IMAGES frames of 8-bit pixels from the decoder's
// pixel FIFO, packs each byte pair into a 16-bit word (first byte = low byte)
// and writes the words to consecutive SDRAM word addresses from BASE_ADDR.
// Ports:
//   iCLK, iRST        SDRAM-domain clock (also the FIFO read clock); async
//                     active-high reset.
//   iTRIGGER          one-cycle start pulse, synchronous to iCLK.
//   iNUM_IMAGES       frames to write (1..64), sampled on an accepted trigger.
//   bus (master)      FIFO read port and wait-request SDRAM write port.
//   oBUSY             high from accepted trigger until the last write completes.
//   oDONE             one-cycle pulse after the last write completes.
//   oFRAMES_DONE      frames fully written in the current run.
//   oERROR            sticky: bad frame count or trigger while not idle;
//                     cleared by reset or the next accepted trigger.
// -----------------------------------------------------------------------------
module sdram_image_writer #(
  parameter int              FRAME_BYTES_LOG2 = sdram_image_writer_pkg::FRAME_BYTES_LOG2,
  parameter int              ADDR_W           = 25,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = {ADDR_W{1'b0}}
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic                        iTRIGGER,
  input  logic [6:0]                  iNUM_IMAGES,
  sdram_image_writer_if.master        bus,
  output logic                        oBUSY,
  output logic                        oDONE,
  output logic [6:0]                  oFRAMES_DONE,
  output logic                        oERROR
);

  import sdram_image_writer_pkg::*;

  // Word index wide enough for 64 frames of 2^(FRAME_BYTES_LOG2-1) words.
  localparam int CNT_W  = FRAME_BYTES_LOG2 + 6;
  // Bits of the word index that select a word within one frame.
  localparam int WIDX_W = FRAME_BYTES_LOG2 - 1;

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    word_idx_q, word_idx_d;
  logic [6:0]          num_q, num_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [6:0]          frames_q, frames_d;
  logic                error_q, error_d;

  logic [CNT_W-1:0]    total_words_s;
  logic                last_word_s;
  logic                frame_end_s;
  logic                fifo_rdreq_s;

  // Run length and position decode from the latched frame count and word index.
  always_comb begin
    total_words_s = CNT_W'(num_q) << WIDX_W;
    last_word_s   = (word_idx_q == (total_words_s - CNT_ONE));
    frame_end_s   = &word_idx_q[WIDX_W-1:0];
  end

  // Next-state and datapath logic for the fetch/capture/write sequence.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    num_d        = num_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    frames_d     = frames_q;
    error_d      = error_q;
    fifo_rdreq_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (iTRIGGER && num_images_ok(iNUM_IMAGES)) begin
          num_d      = iNUM_IMAGES;
          word_idx_d = {CNT_W{1'b0}};
          wr_addr_d  = BASE_ADDR;
          frames_d   = 7'd0;
          error_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = RD_LO;
        end else if (iTRIGGER) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = IDLE;
        end
      end

      // Read only when data is present; wait indefinitely for the decoder.
      RD_LO: begin
        fifo_rdreq_s = ~bus.fifo_empty;
        if (!bus.fifo_empty) begin
          state_d = CAP_LO;
        end else begin
          state_d = RD_LO;
        end
      end

      CAP_LO: begin
        wr_data_d[7:0] = bus.fifo_data;
        state_d        = RD_HI;
      end

      RD_HI: begin
        fifo_rdreq_s = ~bus.fifo_empty;
        if (!bus.fifo_empty) begin
          state_d = CAP_HI;
        end else begin
          state_d = RD_HI;
        end
      end

      CAP_HI: begin
        wr_data_d[15:8] = bus.fifo_data;
        state_d         = WRITE;
      end

      // Address and data registers are untouched while the write is stalled.
      WRITE: begin
        if (!bus.wr_wait) begin
          if (frame_end_s) begin
            frames_d = frames_q + 7'd1;
          end else begin
            frames_d = frames_q;
          end
          if (last_word_s) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            word_idx_d = word_idx_q + CNT_ONE;
            wr_addr_d  = wr_addr_q + ADDR_ONE;
            state_d    = RD_LO;
          end
        end else begin
          state_d = WRITE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A trigger outside IDLE (including the final-write cycle) is rejected.
    if (iTRIGGER && (state_q != IDLE)) begin
      error_d = 1'b1;
    end else begin
      error_d = error_d;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= IDLE;
      word_idx_q <= {CNT_W{1'b0}};
      num_q      <= 7'd0;
      wr_addr_q  <= BASE_ADDR;
      wr_data_q  <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      frames_q   <= 7'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      num_q      <= num_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      frames_q   <= frames_d;
      error_q    <= error_d;
    end
  end

  assign bus.fifo_rdreq = fifo_rdreq_s;
  assign bus.wr_req     = (state_q == WRITE);
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign oBUSY          = busy_q;
  assign oDONE          = done_q;
  assign oFRAMES_DONE   = frames_q;
  assign oERROR         = error_q;

endmodule

// File: tb/tb_sdram_image_writer.sv
// -----------------------------------------------------------------------------
// tb_sdram_image_writer
// Drives the writer with a queue-based FIFO model and a wait-request SDRAM
// responder. Each run's expected write stream is computed from the byte list
// handed to the FIFO: word k goes to BASE+k with data {byte[2k+1], byte[2k]}.
// -----------------------------------------------------------------------------
module tb_sdram_image_writer;

  localparam int FBL2   = 4;
  localparam int ADDR_W = 25;
  localparam int WPF    = 1 << (FBL2 - 1);

  logic       iCLK;
  logic       iRST;
  logic       iTRIGGER;
  logic [6:0] iNUM_IMAGES;
  logic       oBUSY;
  logic       oDONE;
  logic [6:0] oFRAMES_DONE;
  logic       oERROR;

  sdram_image_writer_if #(.ADDR_W(ADDR_W)) bus ();

  sdram_image_writer #(
    .FRAME_BYTES_LOG2 (FBL2),
    .ADDR_W           (ADDR_W),
    .BASE_ADDR        ({ADDR_W{1'b0}})
  ) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iTRIGGER     (iTRIGGER),
    .iNUM_IMAGES  (iNUM_IMAGES),
    .bus          (bus),
    .oBUSY        (oBUSY),
    .oDONE        (oDONE),
    .oFRAMES_DONE (oFRAMES_DONE),
    .oERROR       (oERROR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_errors = 0;

  // FIFO model state
  logic [7:0] fifo_q[$];
  logic [7:0] src_q[$];
  int         feed_gap = 0;
  int         gap_cnt  = 0;
  int         rd_cnt   = 0;
  int         rd_viol  = 0;

  // SDRAM responder / monitor state
  int                wait_len    = 0;
  int                wcnt        = 0;
  int                stable_viol = 0;
  int                done_cnt    = 0;
  logic [ADDR_W-1:0] hold_addr;
  logic [15:0]       hold_data;
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [15:0]       wr_data_log[$];
  logic [6:0]        fd_log[$];
  logic [6:0]        last_fd = 7'd0;

  logic [7:0]        exp_bytes[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge iCLK);
    #1;
  endtask

  // FIFO model: normal-mode read (data the cycle after rdreq) plus paced refill.
  always @(posedge iCLK) begin
    if (bus.fifo_rdreq) begin
      if (fifo_q.size() == 0) begin
        rd_viol++;
      end else begin
        bus.fifo_data <= fifo_q.pop_front();
        rd_cnt++;
      end
    end
    if (src_q.size() > 0) begin
      if (feed_gap == 0) begin
        while (src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
      end else if (gap_cnt >= feed_gap - 1) begin
        fifo_q.push_back(src_q.pop_front());
        gap_cnt = 0;
      end else begin
        gap_cnt++;
      end
    end
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  // SDRAM responder: stalls each write for wait_len cycles, logs completions,
  // and flags any address/data movement during a stall.
  always @(negedge iCLK) begin
    if (iRST) begin
      wcnt        = 0;
      bus.wr_wait = 1'b0;
    end else begin
      if (bus.wr_req) begin
        if (wcnt > 0 && (bus.wr_addr !== hold_addr || bus.wr_data !== hold_data))
          stable_viol++;
        if (wcnt < wait_len) begin
          if (wcnt == 0) begin
            hold_addr = bus.wr_addr;
            hold_data = bus.wr_data;
          end
          bus.wr_wait = 1'b1;
          wcnt++;
        end else begin
          bus.wr_wait = 1'b0;
          wr_addr_log.push_back(bus.wr_addr);
          wr_data_log.push_back(bus.wr_data);
          wcnt = 0;
        end
      end else begin
        bus.wr_wait = 1'b0;
        wcnt        = 0;
      end
      if (oDONE) done_cnt++;
      if (oFRAMES_DONE != last_fd) begin
        if (oFRAMES_DONE != 7'd0) fd_log.push_back(oFRAMES_DONE);
        last_fd = oFRAMES_DONE;
      end
    end
  end

  task automatic clear_run();
    fifo_q.delete();
    src_q.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    fd_log.delete();
    last_fd     = oFRAMES_DONE;
    gap_cnt     = 0;
    rd_cnt      = 0;
    rd_viol     = 0;
    stable_viol = 0;
    done_cnt    = 0;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_busy"},   32'(oBUSY), 32'd0);
    check_eq({tag, "_done"},   32'(oDONE), 32'd0);
    check_eq({tag, "_frames"}, 32'(oFRAMES_DONE), 32'd0);
    check_eq({tag, "_error"},  32'(oERROR), 32'd0);
    check_eq({tag, "_wrreq"},  32'(bus.wr_req), 32'd0);
    check_eq({tag, "_addr"},   32'(bus.wr_addr), 32'd0);
    check_eq({tag, "_data"},   32'(bus.wr_data), 32'd0);
    check_eq({tag, "_rdreq"},  32'(bus.fifo_rdreq), 32'd0);
  endtask

  // One run: n frames, FIFO refill pacing, write stall length, optional
  // ramp data, optional mid-run trigger, optional reset after some writes.
  task automatic run_job(input int n, input int gap, input int wlen, input bit ramp,
                         input bit mid_trig, input int abort_after, input string tag);
    int         budget;
    int         cyc;
    int         bad;
    logic [7:0] b;
    logic [15:0] exp_d;

    clear_run();
    exp_bytes.delete();
    for (int i = 0; i < 16 * n + 2; i++) begin
      if (ramp) b = 8'(i);
      else if (i % 7 == 3) b = 8'hFE;
      else b = 8'($urandom);
      exp_bytes.push_back(b);
    end
    feed_gap = gap;
    wait_len = wlen;
    foreach (exp_bytes[i]) src_q.push_back(exp_bytes[i]);
    repeat (2) tick();

    iNUM_IMAGES = 7'(n);
    iTRIGGER    = 1'b1;
    tick();
    iTRIGGER    = 1'b0;
    check_eq({tag, "_busy_start"}, 32'(oBUSY), 32'd1);
    check_eq({tag, "_err_clear"},  32'(oERROR), 32'd0);

    budget = 8 * n * (5 + wlen) + 16 * (n + 1) * gap + 100;
    cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      if (mid_trig) begin
        iTRIGGER    = (cyc == 10);
        iNUM_IMAGES = 7'd3;
      end
      if (abort_after > 0 && wr_addr_log.size() >= abort_after) break;
      tick();
      cyc++;
    end
    iTRIGGER = 1'b0;

    if (abort_after > 0) begin
      tick();
      iRST = 1'b1;
      #1;
      check_idle_zero({tag, "_rst"});
      fifo_q.delete();
      src_q.delete();
      repeat (2) tick();
      iRST = 1'b0;
      repeat (5) tick();
      check_eq({tag, "_no_done"}, 32'(done_cnt), 32'd0);
      check_eq({tag, "_busy_after"}, 32'(oBUSY), 32'd0);
      return;
    end

    check_eq({tag, "_done_in_budget"}, 32'(cyc < budget), 32'd1);
    if (gap == 0 && wlen == 0 && !mid_trig)
      check_eq({tag, "_throughput"}, 32'(cyc <= 5 * 8 * n + 1), 32'd1);
    repeat (4) tick();

    check_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_busy_end"},    32'(oBUSY), 32'd0);
    check_eq({tag, "_frames"},      32'(oFRAMES_DONE), 32'(n));
    check_eq({tag, "_wr_count"},    32'(wr_addr_log.size()), 32'(WPF * n));
    check_eq({tag, "_rd_count"},    32'(rd_cnt), 32'(16 * n));
    check_eq({tag, "_leftover"},    32'(fifo_q.size() + src_q.size()), 32'd2);
    check_eq({tag, "_rd_empty"},    32'(rd_viol), 32'd0);
    check_eq({tag, "_stable"},      32'(stable_viol), 32'd0);
    check_eq({tag, "_error_end"},   32'(oERROR), 32'(mid_trig));

    bad = 0;
    for (int k = 0; k < wr_addr_log.size() && k < WPF * n; k++) begin
      exp_d = {exp_bytes[2*k+1], exp_bytes[2*k]};
      if (wr_addr_log[k] !== ADDR_W'(k) || wr_data_log[k] !== exp_d) bad++;
    end
    check_eq({tag, "_stream"}, 32'(bad), 32'd0);
    if (wr_addr_log.size() > 0) begin
      check_eq({tag, "_first_data"}, 32'(wr_data_log[0]), 32'({exp_bytes[1], exp_bytes[0]}));
      check_eq({tag, "_last_addr"},  32'(wr_addr_log[wr_addr_log.size()-1]), 32'(WPF * n - 1));
    end

    bad = 0;
    foreach (fd_log[i]) if (fd_log[i] != 7'(i + 1)) bad++;
    check_eq({tag, "_fd_steps"}, 32'(fd_log.size()), 32'(n));
    check_eq({tag, "_fd_order"}, 32'(bad), 32'd0);
  endtask

  initial begin
    iRST        = 1'b1;
    iTRIGGER    = 1'b0;
    iNUM_IMAGES = 7'd0;
    repeat (3) tick();
    check_idle_zero("reset");
    iRST = 1'b0;
    repeat (2) tick();
    check_idle_zero("post_reset");

    // Single frame, ramp data, no stalls.
    run_job(1, 0, 0, 1'b1, 1'b0, 0, "single");

    // Starved FIFO: one byte every 10 cycles, two frames.
    run_job(2, 10, 0, 1'b0, 1'b0, 0, "starved");

    // Every write stalled for 3 cycles.
    run_job(2, 0, 3, 1'b0, 1'b0, 0, "wait3");

    // Illegal frame counts.
    clear_run();
    iNUM_IMAGES = 7'd0;
    iTRIGGER    = 1'b1;
    tick();
    iTRIGGER    = 1'b0;
    check_eq("bad0_error", 32'(oERROR), 32'd1);
    check_eq("bad0_busy",  32'(oBUSY), 32'd0);
    repeat (2) tick();
    iNUM_IMAGES = 7'd65;
    iTRIGGER    = 1'b1;
    tick();
    iTRIGGER    = 1'b0;
    check_eq("bad65_error", 32'(oERROR), 32'd1);
    check_eq("bad65_busy",  32'(oBUSY), 32'd0);
    repeat (10) tick();
    check_eq("bad_no_writes", 32'(wr_addr_log.size()), 32'd0);
    check_eq("bad_no_reads",  32'(rd_cnt), 32'd0);
    check_eq("bad_error_sticky", 32'(oERROR), 32'd1);

    // Valid trigger afterwards clears the error.
    run_job(1, 0, 0, 1'b0, 1'b0, 0, "recover");

    // Second trigger during a one-frame run.
    run_job(1, 0, 0, 1'b0, 1'b1, 0, "midtrig");

    // A few randomized runs.
    for (int r = 0; r < 3; r++)
      run_job(int'($urandom_range(4, 1)), int'($urandom_range(3, 0)),
              int'($urandom_range(3, 0)), 1'b0, 1'b0, 0, $sformatf("rand%0d", r));

    // Reset after 3 writes, then the maximum frame count.
    run_job(2, 0, 0, 1'b0, 1'b0, 3, "abort");
    run_job(64, 0, 0, 1'b0, 1'b0, 0, "max64");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
